dg0045_display_scan: RTL and testbench



---
 rtl/dg0045_display_scan.sv | 168 ++++++++++++++++
 tb/tb_dg0045_display_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dg0045_display_scan.sv
// DG0045 display/keyboard peripheral: ND-strobed digit shift buffer, multiplexed
// 7-segment scan and debounced 4-column key matrix. Define DG0045_LZB_EN for leading-zero blanking.
module dg0045_key_deb #(
   parameter int DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       smp_en,
   input  logic [3:0] sample,
   output logic [3:0] state
);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

   logic [3:0]    last, last_nxt;
   logic [CW-1:0] cnt, cnt_nxt;

   always_comb begin
      last_nxt = last;
      cnt_nxt  = cnt;
      if (sample == last) begin
         if (cnt != CMAX) cnt_nxt = cnt + CW'(1);
      end else begin
         last_nxt = sample;
         cnt_nxt  = '0;
      end
   end

   // Acceptance looks at the post-update count so DEBOUNCE=1 takes the sample at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         last  <= '0;
         cnt   <= '0;
         state <= '0;
      end else if (smp_en) begin
         last <= last_nxt;
         cnt  <= cnt_nxt;
         if (cnt_nxt == CMAX) state <= last_nxt;
      end
   end
endmodule

module dg0045_display_scan #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 1024,
   parameter int DEBOUNCE   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            nL,
   input  logic                  ND,
   input  logic [3:0]            key_row,
   output logic [3:0]            kin,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] dig,
   output logic                  frame_done
);
   localparam int SW = $clog2(NUM_DIGITS);
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [SW-1:0] LAST_DIG = SW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRE_KEY  = PW'(SCAN_DIV - 3);

   logic                        nd_sync1, nd_sync2;
   logic [3:0]                  nl_sync1;
   logic [1:0]                  nl_sync2;  // only L[1:0] is used after the second stage
   logic                        strobe;
   logic [NUM_DIGITS-1:0][3:0]  dbuf;
   logic [SW-1:0]               fcnt, scan_idx;
   logic [PW-1:0]               pre;
   logic [NUM_DIGITS-1:0]       dig_nxt, lz_blank;
   logic [3:0]                  key_smp;
   logic [3:0][3:0]             key_state;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         nd_sync1 <= 1'b1;
         nd_sync2 <= 1'b1;
         nl_sync1 <= 4'hF;
         nl_sync2 <= 2'b11;
      end else begin
         nd_sync1 <= ND;
         nd_sync2 <= nd_sync1;
         nl_sync1 <= nL;
         nl_sync2 <= nl_sync1[1:0];
      end
   end

   assign strobe = nd_sync2 & ~nd_sync1;

   always_ff @(posedge clk) begin
      if (reset) begin
         dbuf       <= '0;
         fcnt       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= strobe && (fcnt == LAST_DIG);
         if (strobe) begin
            dbuf <= {dbuf[NUM_DIGITS-2:0], ~nl_sync1};
            fcnt <= (fcnt == LAST_DIG) ? '0 : fcnt + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre      <= '0;
         scan_idx <= '0;
      end else if (pre == PRE_LAST) begin
         pre      <= '0;
         scan_idx <= (scan_idx == LAST_DIG) ? '0 : scan_idx + SW'(1);
      end else begin
         pre <= pre + PW'(1);
      end
   end

`ifdef DG0045_LZB_EN
   always_comb begin
      logic run;
      lz_blank = '0;
      run      = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         run         = run & (dbuf[k] == 4'h0);
         lz_blank[k] = run;
      end
   end
`else
   assign lz_blank = '0;
`endif

   always_comb begin
      dig_nxt = '0;
      if (pre >= PW'(2)) dig_nxt[scan_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dig <= '0;
         seg <= '0;
      end else begin
         dig <= dig_nxt;
         seg <= lz_blank[scan_idx] ? 7'h00 : hex7(dbuf[scan_idx]);
      end
   end

   // Rows are sampled late in the slot so the blanked start of the slot has settled the matrix.
   for (genvar c = 0; c < 4; c++) begin : g_col
      assign key_smp[c] = (pre == PRE_KEY) && (scan_idx == SW'(c));
      dg0045_key_deb #(.DEBOUNCE(DEBOUNCE)) u_deb (
         .clk    (clk),
         .reset  (reset),
         .smp_en (key_smp[c]),
         .sample (key_row),
         .state  (key_state[c])
      );
   end

   assign kin = key_state[~nl_sync2];
endmodule

// File: tb/tb_dg0045_display_scan.sv
// Randomized self-checking bench for dg0045_display_scan against a cycle-count based
// reference model (scan position from edge count, buffer as a digit array, keys as sample history).
module tb_dg0045_display_scan;
   localparam int N  = 8;
   localparam int SD = 8;
   localparam int DB = 3;

   logic         clk = 1'b0, reset = 1'b1, ND = 1'b1;
   logic [3:0]   nL = 4'hF, key_row = 4'h0;
   logic [3:0]   kin;
   logic [6:0]   seg;
   logic [N-1:0] dig;
   logic         frame_done;

   dg0045_display_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk(clk), .reset(reset), .nL(nL), .ND(ND), .key_row(key_row),
      .kin(kin), .seg(seg), .dig(dig), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   int k = 0;
   int mbuf[N];
   int mcount = 0;
   int kstate[4];
   int hist[4][DB];
   int hn[4];
   int exp_dig = 0, exp_seg = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int hex7(input int v);
      int t[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                    'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
      return t[v & 15];
   endfunction

   function automatic int seg_of(input int s);
`ifdef DG0045_LZB_EN
      bit all_zero = 1'b1;
      for (int j = s; j < N; j++) if (mbuf[j] != 0) all_zero = 1'b0;
      if (s >= 1 && all_zero) return 0;
`endif
      return hex7(mbuf[s]);
   endfunction

   task automatic model_reset();
      k = 0;
      mcount = 0;
      for (int j = 0; j < N; j++) mbuf[j] = 0;
      for (int c = 0; c < 4; c++) begin
         kstate[c] = 0;
         hn[c] = 1;
         hist[c][0] = 0;
      end
   endtask

   // Accept a column value once the last DB samples (reset counts as one 0 sample) agree.
   task automatic key_sample(input int c, input int v);
      bit same = 1'b1;
      if (hn[c] < DB) begin
         hist[c][hn[c]] = v;
         hn[c]++;
      end else begin
         for (int j = 0; j < DB - 1; j++) hist[c][j] = hist[c][j+1];
         hist[c][DB-1] = v;
      end
      for (int j = 0; j < hn[c]; j++) if (hist[c][j] != v) same = 1'b0;
      if (hn[c] == DB && same) kstate[c] = v;
   endtask

   // One clock: inputs stay as driven at the previous negedge; model steps at posedge.
   task automatic cyc();
      int  p, s;
      logic rst_edge;
      p = k % SD;
      s = (k / SD) % N;
      rst_edge = reset;
      @(posedge clk);
      if (rst_edge) begin
         model_reset();
         exp_dig = 0;
         exp_seg = 0;
      end else begin
         if (p == SD - 3 && s < 4) key_sample(s, int'(key_row));
         exp_dig = (p < 2) ? 0 : (1 << s);
         exp_seg = seg_of(s);
         k++;
      end
      @(negedge clk);
   endtask

   task automatic scan_chk(input int n, input int keyrate);
      repeat (n) begin
         if (keyrate > 0 && $urandom_range(0, keyrate - 1) == 0) key_row = 4'($urandom);
         cyc();
         chk("dig", dig, exp_dig);
         chk("seg", seg, exp_seg);
         chk("kin", kin, kstate[int'(~nL & 4'h3)]);
         chk("frame_done_idle", frame_done, 0);
      end
   endtask

   // frame_done position counts the cycle in which ND falls as cycle 1.
   task automatic nd_write(input int v, input int len);
      int pos, exp_pos;
      pos = 0;
      nL = ~4'(v);
      ND = 1'b0;
      for (int i = 1; i <= len + 4; i++) begin
         if (i == len + 1) ND = 1'b1;
         cyc();
         if (frame_done) pos = (pos == 0) ? i + 1 : 99;
      end
      for (int j = N - 1; j >= 1; j--) mbuf[j] = mbuf[j-1];
      mbuf[0] = v & 15;
      mcount++;
      exp_pos = 0;
      if (mcount == N) begin
         mcount = 0;
         exp_pos = 3;
      end
      chk("frame_done_pos", pos, exp_pos);
   endtask

   task automatic rst(input int n);
      reset = 1'b1;
      ND = 1'b1;
      repeat (n) begin
         cyc();
         chk("rst_dig", dig, 0);
         chk("rst_seg", seg, 0);
         chk("rst_kin", kin, 0);
         chk("rst_frame_done", frame_done, 0);
      end
      reset = 1'b0;
   endtask

   task automatic to_col(input int c);
      int b = 0;
      while (!((k % SD) == SD - 3 && ((k / SD) % N) == c) && b < 3000) begin
         cyc();
         b++;
      end
      if (b >= 3000) chk("col_wait_timeout", 1, 0);
   endtask

   task automatic show_digit(input int d, input int exp, input string tag);
      int b = 0;
      cyc();
      while (dig !== N'(1 << d) && b < 2000) begin
         cyc();
         b++;
      end
      chk({tag, "_dig"}, dig, 1 << d);
      chk(tag, seg, exp);
   endtask

   initial begin
      int pat[6] = '{5, 5, 0, 5, 5, 5};
      int pexp[6] = '{0, 0, 0, 0, 0, 5};
      int lzb[8] = '{0, 0, 0, 0, 0, 3, 0, 5};

      rst(3);
      for (int v = 1; v <= 8; v++) nd_write(v, 4);
      scan_chk(2 * SD * N, 0);
      show_digit(0, 'h7F, "buf0_is_8");
      show_digit(7, 'h06, "buf7_is_1");

      nd_write(10, 4);
      show_digit(0, 'h77, "seg_A");
      scan_chk(SD * N + 5, 0);

      nL = 4'hD;
      repeat (3) cyc();
      for (int i = 0; i < 6; i++) begin
         to_col(2);
         key_row = 4'(pat[i]);
         cyc();
         chk("kin_debounce", kin, pexp[i]);
      end
      scan_chk(3 * SD * N, 0);

      nd_write(int'($urandom_range(0, 15)), 200);
      scan_chk(SD * N + 3, 0);

      for (int i = 0; i < 3; i++) nd_write(int'($urandom_range(0, 15)), 4);
      nL = 4'hD;
      repeat (3) cyc();
      chk("kin_pre_reset", kin, 5);
      rst(4);
      for (int i = 0; i < 8; i++) nd_write(int'($urandom_range(0, 15)), 4);
      scan_chk(SD * N, 0);

      rst(2);
      for (int i = 0; i < 8; i++) nd_write(lzb[i], 3);
`ifdef DG0045_LZB_EN
      for (int d = 3; d < 8; d++) show_digit(d, 'h00, "lzb_blank");
`else
      for (int d = 3; d < 8; d++) show_digit(d, 'h3F, "zero_shown");
`endif
      show_digit(2, 'h4F, "digit2_3");
      show_digit(1, 'h3F, "digit1_0");
      show_digit(0, 'h6D, "digit0_5");
      scan_chk(SD * N + 4, 0);

      for (int r = 0; r < 25; r++) begin
         nd_write(int'($urandom_range(0, 15)), int'($urandom_range(2, 12)));
         scan_chk(int'($urandom_range(20, 150)), 300);
      end
      scan_chk(1500, 400);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
